// File: rtl/datapath_pkg.sv
// Shared types for the single-bus datapath: bus source and ALU operation
// encodings, FSM state types and a width helper.
package datapath_pkg;

   typedef enum logic [3:0] {
      SRC_REG    = 4'd0,
      SRC_PC     = 4'd1,
      SRC_IR     = 4'd2,
      SRC_Y      = 4'd3,
      SRC_ZLO    = 4'd4,
      SRC_ZHI    = 4'd5,
      SRC_LO     = 4'd6,
      SRC_HI     = 4'd7,
      SRC_MDR    = 4'd8,
      SRC_CONST0 = 4'd9
   } bus_src_t;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_SHR  = 4'd4,
      OP_SHRA = 4'd5,
      OP_SHL  = 4'd6,
      OP_ROR  = 4'd7,
      OP_ROL  = 4'd8,
      OP_NEG  = 4'd9,
      OP_NOT  = 4'd10,
      OP_MUL  = 4'd11,
      OP_DIV  = 4'd12
   } alu_op_t;

   typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

   typedef enum logic [1:0] {MEM_IDLE, MEM_RD_WAIT, MEM_WR_WAIT} mem_state_t;

   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

endpackage

// File: rtl/iterative_muldiv.sv
// Radix-2 signed multiply / restoring divide on operand magnitudes, one bit
// per cycle, with sign fix-up in DONE and a one-cycle done pulse afterwards.
module iterative_muldiv
   import datapath_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              Clock,
   input  logic              Clear,
   input  logic              start,
   input  alu_op_t           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CNT_W = clog2(DATA_W) + 1;

   md_state_t           state_q, state_d;
   logic                is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic                dz_q, dz_d, done_q, done_d;
   logic [DATA_W-1:0]   acc_q, acc_d, lo_q, lo_d, m_q, m_d, a_raw_q, a_raw_d;
   logic [DATA_W-1:0]   hi_res_q, hi_res_d, lo_res_q, lo_res_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   mag_a, mag_b;
   logic [DATA_W:0]     mul_sum, div_shift, div_trial;
   logic [2*DATA_W-1:0] product;

   assign mag_a     = a[DATA_W-1] ? -a : a;
   assign mag_b     = b[DATA_W-1] ? -b : b;
   assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, m_q} : '0);
   assign div_shift = {acc_q, lo_q[DATA_W-1]};
   assign div_trial = div_shift - {1'b0, m_q};
   assign product   = {acc_q, lo_q};

   always_comb begin
      state_d   = state_q;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      done_d    = 1'b0;
      acc_d     = acc_q;
      lo_d      = lo_q;
      m_d       = m_q;
      a_raw_d   = a_raw_q;
      hi_res_d  = hi_res_q;
      lo_res_d  = lo_res_q;
      cnt_d     = cnt_q;
      case (state_q)
         MD_IDLE: begin
            // done_q still high means the result is being handed over; stay quiet
            if (start && !done_q && (op == OP_MUL || op == OP_DIV)) begin
               is_div_d  = (op == OP_DIV);
               neg_d     = a[DATA_W-1] ^ b[DATA_W-1];
               neg_rem_d = a[DATA_W-1];
               dz_d      = (op == OP_DIV) && (b == '0);
               a_raw_d   = a;
               acc_d     = '0;
               cnt_d     = '0;
               lo_d      = (op == OP_DIV) ? mag_a : mag_b;
               m_d       = (op == OP_DIV) ? mag_b : mag_a;
               state_d   = ((op == OP_DIV) && (b == '0)) ? MD_DONE : MD_RUN;
            end
         end
         MD_RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (is_div_q) begin
               if (!div_trial[DATA_W]) begin
                  acc_d = div_trial[DATA_W-1:0];
                  lo_d  = {lo_q[DATA_W-2:0], 1'b1};
               end else begin
                  acc_d = div_shift[DATA_W-1:0];
                  lo_d  = {lo_q[DATA_W-2:0], 1'b0};
               end
            end else begin
               acc_d = mul_sum[DATA_W:1];
               lo_d  = {mul_sum[0], lo_q[DATA_W-1:1]};
            end
            if (cnt_q == CNT_W'(DATA_W - 1)) state_d = MD_DONE;
         end
         MD_DONE: begin
            state_d = MD_IDLE;
            done_d  = 1'b1;
            if (dz_q) begin
               lo_res_d = '1;
               hi_res_d = a_raw_q;
            end else if (is_div_q) begin
               lo_res_d = neg_q ? -lo_q : lo_q;
               hi_res_d = neg_rem_q ? -acc_q : acc_q;
            end else begin
               {hi_res_d, lo_res_d} = neg_q ? -product : product;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         state_q   <= MD_IDLE;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
         done_q    <= 1'b0;
         acc_q     <= '0;
         lo_q      <= '0;
         m_q       <= '0;
         a_raw_q   <= '0;
         hi_res_q  <= '0;
         lo_res_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
         done_q    <= done_d;
         acc_q     <= acc_d;
         lo_q      <= lo_d;
         m_q       <= m_d;
         a_raw_q   <= a_raw_d;
         hi_res_q  <= hi_res_d;
         lo_res_q  <= lo_res_d;
         cnt_q     <= cnt_d;
      end
   end

   assign busy = (state_q != MD_IDLE) || done_q;
   assign done = done_q;
   assign hi   = hi_res_q;
   assign lo   = lo_res_q;

endmodule

// File: rtl/param_bus_datapath.sv
// Single-bus datapath: register file, special registers, bus mux, one-cycle
// ALU, memory handshake FSM and the iterative multiply/divide engine.
module param_bus_datapath
   import datapath_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int R0_ZERO  = 1,
   parameter int PC_STEP  = 1
) (
   input  logic                       Clock,
   input  logic                       Clear,
   input  logic [3:0]                 bus_src,
   input  logic [clog2(NUM_REGS)-1:0] reg_rsel,
   input  logic [clog2(NUM_REGS)-1:0] reg_wsel,
   input  logic                       reg_we,
   input  logic                       PCin,
   input  logic                       IRin,
   input  logic                       Yin,
   input  logic                       MARin,
   input  logic                       MDRin,
   input  logic                       LOin,
   input  logic                       HIin,
   input  logic                       Zin,
   input  logic                       IncPC,
   input  logic [3:0]                 alu_op,
   input  logic                       md_start,
   output logic                       md_busy,
   input  logic                       mem_rd,
   input  logic                       mem_wr,
   input  logic                       mem_ready,
   output logic [DATA_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       mem_req_rd,
   output logic                       mem_req_wr,
   output logic [DATA_W-1:0]          ir_out,
   output logic [DATA_W-1:0]          bus_out
);

   localparam int RSEL_W = clog2(NUM_REGS);
   localparam int SH_W   = clog2(DATA_W);

   bus_src_t          bus_sel;
   alu_op_t           op_sel;
   logic [DATA_W-1:0] bus_val, alu_res, rf_rd;
   logic [DATA_W-1:0] rf_view [NUM_REGS];
   logic [SH_W-1:0]   sh;
   logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, y_q, y_d, mar_q, mar_d, mdr_q, mdr_d;
   logic [DATA_W-1:0] lo_q, lo_d, hi_q, hi_d, zlo_q, zlo_d, zhi_q, zhi_d;
   logic [DATA_W-1:0] md_hi, md_lo;
   logic              md_done;
   mem_state_t        mem_state_q, mem_state_d;

   assign bus_sel = bus_src_t'(bus_src);
   assign op_sel  = alu_op_t'(alu_op);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
         if (R0_ZERO != 0 && gi == 0) begin : g_zero
            assign rf_view[gi] = '0;
         end else begin : g_store
            logic [DATA_W-1:0] r_q;
            always_ff @(posedge Clock) begin
               if (Clear)                                       r_q <= '0;
               else if (reg_we && reg_wsel == RSEL_W'(gi))      r_q <= bus_val;
            end
            assign rf_view[gi] = r_q;
         end
      end
   endgenerate

   assign rf_rd = rf_view[reg_rsel];

   always_comb begin
      case (bus_sel)
         SRC_REG: bus_val = rf_rd;
         SRC_PC:  bus_val = pc_q;
         SRC_IR:  bus_val = ir_q;
         SRC_Y:   bus_val = y_q;
         SRC_ZLO: bus_val = zlo_q;
         SRC_ZHI: bus_val = zhi_q;
         SRC_LO:  bus_val = lo_q;
         SRC_HI:  bus_val = hi_q;
         SRC_MDR: bus_val = mdr_q;
         default: bus_val = '0;
      endcase
   end

   // Shifts and rotates move Y by the low bits of the bus; NEG/NOT act on the bus.
   assign sh = bus_val[SH_W-1:0];

   always_comb begin
      case (op_sel)
         OP_ADD:  alu_res = y_q + bus_val;
         OP_SUB:  alu_res = y_q - bus_val;
         OP_AND:  alu_res = y_q & bus_val;
         OP_OR:   alu_res = y_q | bus_val;
         OP_SHR:  alu_res = y_q >> sh;
         OP_SHRA: alu_res = $signed(y_q) >>> sh;
         OP_SHL:  alu_res = y_q << sh;
         OP_ROR:  alu_res = (y_q >> sh) | (y_q << (DATA_W - int'(sh)));
         OP_ROL:  alu_res = (y_q << sh) | (y_q >> (DATA_W - int'(sh)));
         OP_NEG:  alu_res = -bus_val;
         OP_NOT:  alu_res = ~bus_val;
         default: alu_res = '0;
      endcase
   end

   iterative_muldiv #(.DATA_W(DATA_W)) u_muldiv (
      .Clock (Clock),
      .Clear (Clear),
      .start (md_start),
      .op    (op_sel),
      .a     (y_q),
      .b     (bus_val),
      .busy  (md_busy),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo)
   );

   always_comb begin
      mem_state_d = mem_state_q;
      case (mem_state_q)
         MEM_IDLE: begin
            if (mem_rd)      mem_state_d = MEM_RD_WAIT;
            else if (mem_wr) mem_state_d = MEM_WR_WAIT;
         end
         MEM_RD_WAIT: if (mem_ready) mem_state_d = MEM_IDLE;
         MEM_WR_WAIT: if (mem_ready) mem_state_d = MEM_IDLE;
         default:     mem_state_d = MEM_IDLE;
      endcase
   end

   always_comb begin
      pc_d  = PCin  ? bus_val : pc_q;
      ir_d  = IRin  ? bus_val : ir_q;
      y_d   = Yin   ? bus_val : y_q;
      lo_d  = LOin  ? bus_val : lo_q;
      hi_d  = HIin  ? bus_val : hi_q;
      // MAR is frozen while a memory request is outstanding.
      mar_d = (MARin && mem_state_q == MEM_IDLE) ? bus_val : mar_q;
      mdr_d = mdr_q;
      if (mem_state_q == MEM_RD_WAIT && mem_ready) mdr_d = mem_rdata;
      else if (MDRin)                              mdr_d = bus_val;
      zlo_d = zlo_q;
      zhi_d = zhi_q;
      if (md_done) begin
         zlo_d = md_lo;
         zhi_d = md_hi;
      end else if (Zin && !md_busy) begin
         zlo_d = IncPC ? bus_val + DATA_W'(PC_STEP) : alu_res;
         zhi_d = '0;
      end
   end

   always_ff @(posedge Clock) begin
      if (Clear) begin
         pc_q        <= '0;
         ir_q        <= '0;
         y_q         <= '0;
         mar_q       <= '0;
         mdr_q       <= '0;
         lo_q        <= '0;
         hi_q        <= '0;
         zlo_q       <= '0;
         zhi_q       <= '0;
         mem_state_q <= MEM_IDLE;
      end else begin
         pc_q        <= pc_d;
         ir_q        <= ir_d;
         y_q         <= y_d;
         mar_q       <= mar_d;
         mdr_q       <= mdr_d;
         lo_q        <= lo_d;
         hi_q        <= hi_d;
         zlo_q       <= zlo_d;
         zhi_q       <= zhi_d;
         mem_state_q <= mem_state_d;
      end
   end

   assign mem_req_rd = (mem_state_q == MEM_RD_WAIT);
   assign mem_req_wr = (mem_state_q == MEM_WR_WAIT);
   assign mem_addr   = mar_q;
   assign mem_wdata  = mdr_q;
   assign ir_out     = ir_q;
   assign bus_out    = bus_val;

endmodule

// File: tb/tb_param_bus_datapath.sv
// Directed bench for param_bus_datapath: expected values go into a scoreboard
// queue as stimulus is applied and are popped when the DUT output is sampled.
module tb_param_bus_datapath;
   import datapath_pkg::*;

   logic        clk = 1'b0;
   logic        clear;
   logic [3:0]  bus_src, reg_rsel, reg_wsel, alu_op;
   logic        reg_we, PCin, IRin, Yin, MARin, MDRin, LOin, HIin, Zin, IncPC;
   logic        md_start, md_busy, mem_rd, mem_wr, mem_ready, mem_req_rd, mem_req_wr;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, ir_out, bus_out;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   param_bus_datapath #(.DATA_W(32), .NUM_REGS(16), .R0_ZERO(1), .PC_STEP(1)) dut (
      .Clock(clk), .Clear(clear), .bus_src(bus_src), .reg_rsel(reg_rsel),
      .reg_wsel(reg_wsel), .reg_we(reg_we), .PCin(PCin), .IRin(IRin), .Yin(Yin),
      .MARin(MARin), .MDRin(MDRin), .LOin(LOin), .HIin(HIin), .Zin(Zin),
      .IncPC(IncPC), .alu_op(alu_op), .md_start(md_start), .md_busy(md_busy),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_req_rd(mem_req_rd),
      .mem_req_wr(mem_req_wr), .ir_out(ir_out), .bus_out(bus_out)
   );

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus_src = SRC_CONST0; reg_rsel = '0; reg_wsel = '0; reg_we = 0;
      PCin = 0; IRin = 0; Yin = 0; MARin = 0; MDRin = 0; LOin = 0; HIin = 0;
      Zin = 0; IncPC = 0; alu_op = OP_ADD; md_start = 0;
      mem_rd = 0; mem_wr = 0; mem_ready = 0; mem_rdata = '0;
   endtask

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [31:0] obs);
      logic [31:0] exp_v;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
      end else begin
         exp_v = exp_q.pop_front();
         $display("check %s observed=%h expected=%h", tag, obs, exp_v);
         assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
         end
      end
   endtask

   task automatic read_bus(input bus_src_t s, input logic [3:0] sel, output logic [31:0] v);
      bus_src = s;
      reg_rsel = sel;
      #1;
      v = bus_out;
   endtask

   // The memory port is the only way to bring external data onto the bus.
   task automatic mdr_load(input logic [31:0] v);
      mem_rd = 1; cycle(); idle();
      mem_ready = 1; mem_rdata = v; cycle(); idle();
   endtask

   task automatic wait_md(output int n);
      n = 0;
      while (md_busy === 1'b1 && n < 200) begin
         n++;
         cycle();
      end
   endtask

   function automatic logic [31:0] alu_model(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] dbl;
      int          s;
      s   = int'(b[4:0]);
      dbl = {a, a};
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_SHR:  return a >> s;
         OP_SHRA: return 32'($signed(a) >>> s);
         OP_SHL:  return a << s;
         OP_ROR:  begin dbl = dbl >> s; return dbl[31:0]; end
         OP_ROL:  begin dbl = dbl << s; return dbl[63:32]; end
         OP_NEG:  return 32'(0) - b;
         OP_NOT:  return ~b;
         default: return '0;
      endcase
   endfunction

   task automatic md_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input alu_op_t op, input int exp_cycles);
      logic [63:0] p;
      logic [31:0] exp_lo, exp_hi, v;
      int          n;
      if (op == OP_MUL) begin
         p = 64'(longint'($signed(a)) * longint'($signed(b)));
         exp_lo = p[31:0];
         exp_hi = p[63:32];
      end else if (b == 0) begin
         exp_lo = 32'hFFFF_FFFF;
         exp_hi = a;
      end else begin
         exp_lo = 32'(int'(a) / int'(b));
         exp_hi = 32'(int'(a) % int'(b));
      end
      mdr_load(a);
      bus_src = SRC_MDR; Yin = 1; cycle(); idle();
      mdr_load(b);
      bus_src = SRC_MDR; alu_op = op; md_start = 1; cycle(); idle();
      wait_md(n);
      push(32'(exp_cycles)); check({tag, "_busy_cycles"}, 32'(n));
      push(exp_lo); read_bus(SRC_ZLO, 0, v); check({tag, "_zlo"}, v);
      push(exp_hi); read_bus(SRC_ZHI, 0, v); check({tag, "_zhi"}, v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      int          n;
      bus_src_t    srcs[8];
      alu_op_t     ops[11];
      srcs = '{SRC_PC, SRC_IR, SRC_Y, SRC_ZLO, SRC_ZHI, SRC_LO, SRC_HI, SRC_MDR};
      ops  = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL,
               OP_ROR, OP_ROL, OP_NEG, OP_NOT};

      idle(); clear = 1; @(negedge clk); cycle(); clear = 0;

      // Preload every register, then Clear.
      mdr_load(32'h1111_2222);
      bus_src = SRC_MDR; PCin = 1; IRin = 1; Yin = 1; MARin = 1; LOin = 1; HIin = 1;
      reg_we = 1; reg_wsel = 3; Zin = 1; alu_op = OP_ADD; cycle(); idle();
      push(32'h1111_2222); read_bus(SRC_PC, 0, v);  check("preload_pc", v);
      push(32'h1111_2222); read_bus(SRC_ZLO, 0, v); check("preload_zlo", v);
      push(32'h1111_2222); check("preload_ir_out", ir_out);
      clear = 1; cycle(); clear = 0;
      for (int i = 0; i < 8; i++) begin
         push(32'h0); read_bus(srcs[i], 0, v); check($sformatf("reset_%s", srcs[i].name()), v);
      end
      push(32'h0); read_bus(SRC_REG, 3, v); check("reset_r3", v);
      push(32'h0); check("reset_mem_addr", mem_addr);
      push(32'h0); check("reset_md_busy", {31'b0, md_busy});
      push(32'h0); check("reset_mem_req_rd", {31'b0, mem_req_rd});

      // R0 hard-wired to zero; R5 ordinary.
      mdr_load(32'hDEAD_BEEF);
      bus_src = SRC_MDR; reg_we = 1; reg_wsel = 0; cycle(); idle();
      push(32'h0); read_bus(SRC_REG, 0, v); check("r0_reads_zero", v);
      bus_src = SRC_MDR; reg_we = 1; reg_wsel = 5; cycle(); idle();
      push(32'hDEAD_BEEF); read_bus(SRC_REG, 5, v); check("r5_write_read", v);

      // Single-cycle ALU, A=Y, B=bus.
      mdr_load(32'h8000_00F0);
      bus_src = SRC_MDR; Yin = 1; cycle(); idle();
      mdr_load(32'h0000_0004);
      for (int i = 0; i < 11; i++) begin
         bus_src = SRC_MDR; alu_op = ops[i]; Zin = 1; cycle(); idle();
         push(alu_model(ops[i], 32'h8000_00F0, 32'h0000_0004));
         read_bus(SRC_ZLO, 0, v); check($sformatf("alu_%s_zlo", ops[i].name()), v);
         push(32'h0); read_bus(SRC_ZHI, 0, v); check($sformatf("alu_%s_zhi", ops[i].name()), v);
      end

      // Multiply / divide.
      md_case("mul_m6x7",     32'hFFFF_FFFA, 32'd7,         OP_MUL, 34);
      md_case("mul_big",      32'h0001_2345, 32'hFFFF_0000, OP_MUL, 34);
      md_case("div_m7d2",     32'hFFFF_FFF9, 32'd2,         OP_DIV, 34);
      md_case("div_100dm7",   32'd100,       32'hFFFF_FFF9, OP_DIV, 34);
      md_case("div_by_zero",  32'd9,         32'd0,         OP_DIV, 2);

      // Memory read with MAR hold, ready-vs-MDRin priority.
      mdr_load(32'h55);
      bus_src = SRC_MDR; reg_we = 1; reg_wsel = 7; cycle(); idle();
      mdr_load(32'h40);
      bus_src = SRC_MDR; MARin = 1; cycle(); idle();
      mem_rd = 1; cycle(); idle();
      push(32'h1);  check("rd_req_asserted", {31'b0, mem_req_rd});
      push(32'h40); check("rd_mem_addr", mem_addr);
      bus_src = SRC_CONST0; MARin = 1; cycle(); idle();
      cycle(); cycle();
      push(32'h40); check("mar_hold_while_wait", mem_addr);
      push(32'h1);  check("rd_req_held", {31'b0, mem_req_rd});
      mem_ready = 1; mem_rdata = 32'h1234; MDRin = 1; bus_src = SRC_REG; reg_rsel = 7;
      cycle(); idle();
      push(32'h1234); check("mdr_ready_priority", mem_wdata);
      push(32'h0);    check("rd_req_dropped", {31'b0, mem_req_rd});

      // Write handshake.
      mem_wr = 1; cycle(); idle();
      push(32'h1); check("wr_req_asserted", {31'b0, mem_req_wr});
      mem_ready = 1; cycle(); idle();
      push(32'h0); check("wr_req_dropped", {31'b0, mem_req_wr});

      // Clear during RD_WAIT, then a stray ready.
      mem_rd = 1; cycle(); idle();
      push(32'h1); check("rd2_req_asserted", {31'b0, mem_req_rd});
      clear = 1; cycle(); clear = 0;
      push(32'h0); check("clear_drops_req", {31'b0, mem_req_rd});
      mem_ready = 1; mem_rdata = 32'hABCD; cycle(); idle();
      push(32'h0); check("stray_ready_ignored", mem_wdata);
      push(32'h0); check("stray_ready_no_req", {31'b0, mem_req_rd});

      // IncPC, then Zin and md_start while busy are ignored.
      mdr_load(32'h10);
      bus_src = SRC_MDR; PCin = 1; cycle(); idle();
      bus_src = SRC_PC; IncPC = 1; Zin = 1; cycle(); idle();
      push(32'h11); read_bus(SRC_ZLO, 0, v); check("incpc_zlo", v);
      push(32'h0);  read_bus(SRC_ZHI, 0, v); check("incpc_zhi", v);
      mdr_load(32'h3);
      bus_src = SRC_MDR; Yin = 1; cycle(); idle();
      bus_src = SRC_PC; alu_op = OP_MUL; md_start = 1; cycle(); idle();
      bus_src = SRC_MDR; IncPC = 1; Zin = 1; cycle(); idle();
      push(32'h11); read_bus(SRC_ZLO, 0, v); check("zin_ignored_busy", v);
      bus_src = SRC_MDR; alu_op = OP_MUL; md_start = 1; cycle(); idle();
      wait_md(n);
      push(32'h1);  check("busy_bounded", {31'b0, n < 200});
      push(32'h30); read_bus(SRC_ZLO, 0, v); check("restart_ignored_zlo", v);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
